// File: rtl/da_slice_window.sv
// da_slice_window: tap-delay window and bit-slicer for DA FIR filters.
// Each accepted sample shifts into a TAPS-deep delay line, and a snapshot
// of the window is then emitted as DATA_W bit-slices, one per cycle.
//
// Ports:
//   clk, resetn       rising-edge clock, async active-low reset
//   clear             sync flush: zero delay line, abort current frame
//   in_valid/in_ready sample handshake; in_data is the sample
//   slice             bit b of tap k at slice[k]; group g = slice[g*GRP +: GRP]
//   slice_valid       slice valid this cycle
//   slice_first       first slice of the frame
//   slice_msb         slice carries the sign bits
//   frame_done        pulse coincident with the last slice
//
// Build option: define DA_SLICE_LSB_FIRST_EN for LSB-first slice order
// (default is MSB-first).
module da_slice_window #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 64,
    parameter int GRP    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [TAPS-1:0]   slice,
    output logic              slice_valid,
    output logic              slice_first,
    output logic              slice_msb,
    output logic              frame_done
);

    localparam int NGRP = TAPS / GRP;
    localparam int CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   bidx;
    logic            at_last;
    logic            accept;

    logic [DATA_W-1:0] tap    [TAPS];
    logic [DATA_W-1:0] shadow [TAPS];

    assign at_last  = (state_q == SHIFT) && (cnt_q == LAST);
    // A new sample may land on the last slice so frames run back to back.
    assign in_ready = resetn && !clear && ((state_q == IDLE) || at_last);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The shadow takes the post-shift window so the live delay line can
    // accept the next sample while the current frame is still slicing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < TAPS; k++) begin
                tap[k]    <= '0;
                shadow[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) begin
                tap[k]    <= '0;
                shadow[k] <= '0;
            end
        end else if (accept) begin
            tap[0]    <= in_data;
            shadow[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
                tap[k]    <= tap[k-1];
                shadow[k] <= tap[k-1];
            end
        end
    end

`ifdef DA_SLICE_LSB_FIRST_EN
    assign bidx = cnt_q;
`else
    assign bidx = LAST - cnt_q;
`endif

    assign slice_valid = (state_q == SHIFT);
    assign slice_first = slice_valid && (cnt_q == '0);
    assign frame_done  = at_last;

`ifdef DA_SLICE_LSB_FIRST_EN
    assign slice_msb = at_last;
`else
    assign slice_msb = slice_valid && (cnt_q == '0);
`endif

    always_comb begin
        slice = '0;
        for (int g = 0; g < NGRP; g++) begin
            for (int j = 0; j < GRP; j++) begin
                slice[g*GRP + j] = slice_valid && shadow[g*GRP + j][bidx];
            end
        end
    end

endmodule
